apu_triangle_gen3: RTL and testbench

- Parametrised next-generation triangle channel for the APU.
- Combines a programmable timer, linear counter, internal length counter with an NES length lookup table, and a sequencer with selectable triangle or sawtooth waveform.
- Sits beside the pulse/noise channels, driven by the APU frame sequencer pulses and CPU register writes ($4008-$400B map plus a mode register).

---
 rtl/apu_triangle_gen3.sv | 195 +++++++++++++++++++
 tb/tb_apu_triangle_gen3.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/apu_triangle_gen3.sv
// apu_triangle_gen3 -- triangle/sawtooth channel for the APU.
// Timer, linear counter, length counter (NES lookup table) and a sequencer
// whose output is shaped as a triangle or a sawtooth under CPU control.
// Optional build macro: APU_TRI_ULTRASONIC_MUTE_EN. When defined, periods
// below 2 freeze the sequencer and park the output at mid-scale.
module apu_triangle_gen3 #(
    parameter int TIMER_W = 11,
    parameter int SEQ_W   = 5,
    parameter int OUT_W   = SEQ_W - 1,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             channel_en,
    input  logic             cpu_clk,
    input  logic             l_pulse,
    input  logic             e_pulse,
    input  logic [1:0]       a_in,
    input  logic [7:0]       from_cpu,
    input  logic             wren,
    output logic [OUT_W-1:0] wave_out,
    output logic             active_out
);

    // NES length-counter load values, indexed by from_cpu[7:3].
    function automatic logic [LEN_W-1:0] len_lut(input logic [4:0] idx);
        case (idx)
            5'd0:  len_lut = 8'h0A;  5'd1:  len_lut = 8'hFE;
            5'd2:  len_lut = 8'h14;  5'd3:  len_lut = 8'h02;
            5'd4:  len_lut = 8'h28;  5'd5:  len_lut = 8'h04;
            5'd6:  len_lut = 8'h50;  5'd7:  len_lut = 8'h06;
            5'd8:  len_lut = 8'hA0;  5'd9:  len_lut = 8'h08;
            5'd10: len_lut = 8'h3C;  5'd11: len_lut = 8'h0A;
            5'd12: len_lut = 8'h0E;  5'd13: len_lut = 8'h0C;
            5'd14: len_lut = 8'h1A;  5'd15: len_lut = 8'h0E;
            5'd16: len_lut = 8'h0C;  5'd17: len_lut = 8'h10;
            5'd18: len_lut = 8'h18;  5'd19: len_lut = 8'h12;
            5'd20: len_lut = 8'h30;  5'd21: len_lut = 8'h14;
            5'd22: len_lut = 8'h60;  5'd23: len_lut = 8'h16;
            5'd24: len_lut = 8'hC0;  5'd25: len_lut = 8'h18;
            5'd26: len_lut = 8'h48;  5'd27: len_lut = 8'h1A;
            5'd28: len_lut = 8'h10;  5'd29: len_lut = 8'h1C;
            5'd30: len_lut = 8'h20;  5'd31: len_lut = 8'h1E;
            default: len_lut = 8'h00;
        endcase
    endfunction

    logic [TIMER_W-1:0] period_q, period_d;
    logic [TIMER_W-1:0] count_q,  count_d;
    logic [7:0]         ctrl_q,   ctrl_d;
    logic               mode_q,   mode_d;
    logic [6:0]         linear_q, linear_d;
    logic               reload_q, reload_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic [SEQ_W-1:0]   seq_q,    seq_d;

    logic wr_ctrl_s, wr_mode_s, wr_lo_s, wr_hi_s;
    logic tick_s, mute_s;

    assign wr_ctrl_s  = wren && (a_in == 2'd0);
    assign wr_mode_s  = wren && (a_in == 2'd1);
    assign wr_lo_s    = wren && (a_in == 2'd2);
    assign wr_hi_s    = wren && (a_in == 2'd3);
    assign tick_s     = cpu_clk && (count_q == {TIMER_W{1'b0}});
    assign active_out = (length_q != {LEN_W{1'b0}}) && (linear_q != 7'd0);

`ifdef APU_TRI_ULTRASONIC_MUTE_EN
    // Periods 0 and 1 would step faster than is audible; hold the channel.
    assign mute_s = (period_q < TIMER_W'(2));
`else
    assign mute_s = 1'b0;
`endif

    // Register-file writes: ctrl, mode and the two halves of the period.
    always_comb begin
        ctrl_d   = ctrl_q;
        mode_d   = mode_q;
        period_d = period_q;
        if (wr_ctrl_s) begin
            ctrl_d = from_cpu;
        end else if (wr_mode_s) begin
            mode_d = from_cpu[0];
        end else if (wr_lo_s) begin
            period_d[7:0] = from_cpu;
        end else if (wr_hi_s) begin
            period_d[TIMER_W-1:8] = from_cpu[TIMER_W-9:0];
        end else begin
            period_d = period_q;
        end
    end

    // Timer: counts down on cpu_clk and reloads from period at zero; a period
    // write only takes effect at the next reload.
    always_comb begin
        count_d = count_q;
        if (!cpu_clk) begin
            count_d = count_q;
        end else if (count_q == {TIMER_W{1'b0}}) begin
            count_d = period_q;
        end else begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    // Sequencer: advances on a timer tick only while the channel is active.
    always_comb begin
        seq_d = seq_q;
        if (tick_s && active_out && !mute_s) begin
            seq_d = seq_q + SEQ_W'(1);
        end else begin
            seq_d = seq_q;
        end
    end

    // Linear counter and its reload flag; an $400B write sets the flag even
    // when the quarter-frame clears it in the same cycle.
    always_comb begin
        linear_d = linear_q;
        reload_d = reload_q;
        if (e_pulse) begin
            if (reload_q) begin
                linear_d = ctrl_q[6:0];
            end else if (linear_q != 7'd0) begin
                linear_d = linear_q - 7'd1;
            end else begin
                linear_d = linear_q;
            end
            if (!ctrl_q[7]) begin
                reload_d = 1'b0;
            end else begin
                reload_d = reload_q;
            end
        end else begin
            linear_d = linear_q;
        end
        if (wr_hi_s) begin
            reload_d = 1'b1;
        end else begin
            reload_d = reload_d;
        end
    end

    // Length counter: cleared while disabled, a load beats a same-cycle
    // decrement, and it saturates at zero.
    always_comb begin
        length_d = length_q;
        if (!channel_en) begin
            length_d = {LEN_W{1'b0}};
        end else if (wr_hi_s) begin
            length_d = len_lut(from_cpu[7:3]);
        end else if (l_pulse && !ctrl_q[7] && (length_q != {LEN_W{1'b0}})) begin
            length_d = length_q - LEN_W'(1);
        end else begin
            length_d = length_q;
        end
    end

    // Output shaping from the sequencer position.
    always_comb begin
        wave_out = {OUT_W{1'b0}};
        if (mute_s) begin
            wave_out = {1'b1, {(OUT_W-1){1'b0}}};
        end else if (mode_q) begin
            wave_out = seq_q[SEQ_W-1:1];
        end else if (seq_q[SEQ_W-1]) begin
            wave_out = seq_q[OUT_W-1:0];
        end else begin
            wave_out = ~seq_q[OUT_W-1:0];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= {TIMER_W{1'b0}};
            count_q  <= {TIMER_W{1'b0}};
            ctrl_q   <= 8'd0;
            mode_q   <= 1'b0;
            linear_q <= 7'd0;
            reload_q <= 1'b0;
            length_q <= {LEN_W{1'b0}};
            seq_q    <= {SEQ_W{1'b0}};
        end else begin
            period_q <= period_d;
            count_q  <= count_d;
            ctrl_q   <= ctrl_d;
            mode_q   <= mode_d;
            linear_q <= linear_d;
            reload_q <= reload_d;
            length_q <= length_d;
            seq_q    <= seq_d;
        end
    end

endmodule

// File: tb/tb_apu_triangle_gen3.sv
// Scoreboard bench for apu_triangle_gen3: a behavioural model predicts the
// channel state after each clock edge, a monitor compares at the negedge.
module tb_apu_triangle_gen3;

    localparam int TIMER_W = 11;
    localparam int SEQ_W   = 5;
    localparam int OUT_W   = 4;
`ifdef APU_TRI_ULTRASONIC_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             channel_en = 1'b0;
    logic             cpu_clk = 1'b0;
    logic             l_pulse = 1'b0;
    logic             e_pulse = 1'b0;
    logic [1:0]       a_in = 2'd0;
    logic [7:0]       from_cpu = 8'd0;
    logic             wren = 1'b0;
    logic [OUT_W-1:0] wave_out;
    logic             active_out;

    apu_triangle_gen3 #(.TIMER_W(TIMER_W), .SEQ_W(SEQ_W), .OUT_W(OUT_W), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .channel_en(channel_en), .cpu_clk(cpu_clk),
        .l_pulse(l_pulse), .e_pulse(e_pulse), .a_in(a_in), .from_cpu(from_cpu),
        .wren(wren), .wave_out(wave_out), .active_out(active_out)
    );

    always #5 clk = ~clk;

    typedef struct { int wave; int act; } exp_t;
    exp_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit en_r     = 1'b0;

    int lut[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                    12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    // Behavioural channel state (all zero = reset state).
    int m_period = 0, m_count = 0, m_ctrl = 0, m_mode = 0;
    int m_lin = 0, m_reload = 0, m_len = 0, m_seq = 0;

    function automatic int model_wave();
        int half;
        half = (1 << SEQ_W) / 2;
        if (MUTE && m_period < 2) return 1 << (OUT_W - 1);
        if (m_mode != 0) return m_seq / 2;
        if (m_seq < half) return half - 1 - m_seq;
        return m_seq - half;
    endfunction

    task automatic model_step(input bit r, input bit en, input bit cpu, input bit lp,
                              input bit ep, input bit wr, input int a, input int d);
        int  o_ctrl, o_period;
        bit  act, tick;
        if (r) begin
            m_period = 0; m_count = 0; m_ctrl = 0; m_mode = 0;
            m_lin = 0; m_reload = 0; m_len = 0; m_seq = 0;
            return;
        end
        o_ctrl   = m_ctrl;
        o_period = m_period;
        act  = (m_len != 0) && (m_lin != 0);
        tick = cpu && (m_count == 0);
        if (cpu) m_count = (m_count == 0) ? o_period : m_count - 1;
        if (tick && act && !(MUTE && o_period < 2)) m_seq = (m_seq + 1) % (1 << SEQ_W);
        if (ep) begin
            if (m_reload != 0) m_lin = o_ctrl % 128;
            else if (m_lin > 0) m_lin = m_lin - 1;
            if (o_ctrl < 128) m_reload = 0;
        end
        if (wr && a == 3) m_reload = 1;
        if (!en) m_len = 0;
        else if (wr && a == 3) m_len = lut[d / 8];
        else if (lp && m_len > 0 && o_ctrl < 128) m_len = m_len - 1;
        if (wr) begin
            case (a)
                0: m_ctrl = d;
                1: m_mode = d % 2;
                2: m_period = (m_period / 256) * 256 + d;
                3: m_period = (m_period % 256) + (d % (1 << (TIMER_W - 8))) * 256;
                default: m_ctrl = m_ctrl;
            endcase
        end
    endtask

    // One clock: record what the DUT must show after the previous edge, then
    // apply new inputs and advance the model across the next edge.
    task automatic drive(input bit r, input bit en, input bit cpu, input bit lp,
                         input bit ep, input bit wr, input int a, input int d);
        exp_t e;
        @(posedge clk);
        #1;
        e.wave = model_wave();
        e.act  = ((m_len != 0) && (m_lin != 0)) ? 1 : 0;
        sb_q.push_back(e);
        rst = r; channel_en = en; cpu_clk = cpu; l_pulse = lp; e_pulse = ep;
        wren = wr; a_in = 2'(a); from_cpu = 8'(d);
        model_step(r, en, cpu, lp, ep, wr, a, d);
    endtask

    task automatic wr_reg(input int a, input int d);
        drive(1'b0, en_r, 1'b0, 1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, en_r, (i % 2) == 0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic pulse_e();
        drive(1'b0, en_r, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic pulse_l();
        drive(1'b0, en_r, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    // Monitor: pops one expectation per presented sample and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if ($isunknown(wave_out) || int'(wave_out) != e.wave) begin
                    n_fail++;
                    $display("FAIL wave_out: actual %0d required %0d at %0t", wave_out, e.wave, $time);
                end
                n_checks++;
                if ($isunknown(active_out) || int'(active_out) != e.act) begin
                    n_fail++;
                    $display("FAIL active_out: actual %0d required %0d at %0t", active_out, e.act, $time);
                end
            end
        end
    end

    initial begin
        int a, d;
        bit r, cpu, lp, ep, wr;
        // Reset, then the basic bring-up sequence.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        en_r = 1'b1;
        run(2);
        wr_reg(0, 8'h81);
        wr_reg(2, 8'h03);
        wr_reg(3, 8'h08);
        pulse_e();
        run(300);                              // full triangle cycle and wrap
        wr_reg(1, 8'hFF);                      // sawtooth mid-run
        run(200);
        wr_reg(1, 8'h00);
        // Length counter: load 2, decrement to 0, saturate, then load vs l_pulse.
        wr_reg(0, 8'h7F);
        pulse_e();
        wr_reg(3, 8'h18);
        pulse_e();
        run(10);
        pulse_l(); run(6);
        pulse_l(); run(20);
        pulse_l(); run(4);
        drive(1'b0, en_r, 1'b0, 1'b1, 1'b0, 1'b1, 3, 8'h18);
        run(20);
        // Linear counter counts down from 5, then reloads with control set.
        wr_reg(0, 8'h05);
        wr_reg(3, 8'h08);
        for (int i = 0; i < 7; i++) begin pulse_e(); run(9); end
        wr_reg(0, 8'h85);
        for (int i = 0; i < 3; i++) begin pulse_e(); run(9); end
        // e_pulse coincident with a reload write keeps the flag set.
        wr_reg(0, 8'h03);
        drive(1'b0, en_r, 1'b0, 1'b0, 1'b1, 1'b1, 3, 8'h08);
        pulse_e(); run(10);
        // Disable with length 0x50, then write while disabled.
        wr_reg(0, 8'h85); wr_reg(3, 8'h30); pulse_e(); run(6);
        en_r = 1'b0; run(4);
        wr_reg(3, 8'h30); run(6);
        en_r = 1'b1;
        // Very short periods (muted when the option is built in).
        wr_reg(2, 8'h01); wr_reg(3, 8'h08); pulse_e(); run(24);
        wr_reg(2, 8'h00); run(12);
        wr_reg(2, 8'h02); run(24);
        // Reset in the middle of operation, with a reload pending.
        wr_reg(3, 8'h08);
        drive(1'b1, en_r, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        run(4); pulse_e(); run(4);
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            cpu = ($urandom_range(0, 1) == 1);
            lp  = ($urandom_range(0, 15) == 0);
            ep  = ($urandom_range(0, 11) == 0);
            wr  = ($urandom_range(0, 9) == 0);
            a   = $urandom_range(0, 3);
            if (a == 2) d = $urandom_range(0, 7);
            else if (a == 3) d = $urandom_range(0, 31) * 8 + (($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : 0);
            else d = $urandom_range(0, 255);
            drive(r, en_r, cpu, lp, ep, wr, a, d);
        end
        run(2);
        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d pending required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
